// File: rtl/run_splitter_8_pkg.sv
// run_splitter_8_pkg: shared tuple geometry and FSM encoding for the run splitter
package run_splitter_8_pkg;
    localparam int ELEMS = 8;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int TUPLE_W = ELEMS * DEF_DATA_WIDTH;
    localparam logic [TUPLE_W-1:0] TERM_TUPLE = '0;
    typedef enum logic [1:0] {S_LOAD, S_FILL, S_TERM} state_t;
endpackage

// File: rtl/run_splitter_8_fifo.sv
// stream_fifo: show-ahead FIFO with exact registered empty/full flags
module stream_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_data,
    input  logic         i_enq,
    input  logic         i_deq,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_nxt;
    logic do_enq, do_deq;
    always_comb begin
        do_enq = i_enq & ~o_full;
        do_deq = i_deq & ~o_empty;
        count_nxt = count + (AW+1)'(do_enq) - (AW+1)'(do_deq);
        o_data = mem[rd_ptr];
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            o_empty <= 1'b1;
            o_full <= 1'b0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            o_empty <= count_nxt == '0;
            o_full <= count_nxt == (AW+1)'(DEPTH);
        end
    end
    always_ff @(posedge i_clk) begin
        if (do_enq) mem[wr_ptr] <= i_data;
    end
endmodule

// File: rtl/run_splitter_8.sv
// run_splitter_8: cuts an upstream tuple stream into zero-terminated runs alternating between two FIFO ports
module run_splitter_8
    import run_splitter_8_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [ELEMS*DATA_WIDTH-1:0] i_fifo_in,
    input  logic                        i_fifo_in_empty,
    output logic                        o_fifo_in_read,
    input  logic [LEN_W-1:0]            i_run_len,
    input  logic                        i_flush,
    output logic [ELEMS*DATA_WIDTH-1:0] o_fifo_1,
    output logic                        o_fifo_1_empty,
    input  logic                        i_fifo_1_read,
    output logic [ELEMS*DATA_WIDTH-1:0] o_fifo_2,
    output logic                        o_fifo_2_empty,
    input  logic                        i_fifo_2_read,
    output logic [15:0]                 o_run_count,
    output logic                        o_busy
);
    localparam int TW = ELEMS * DATA_WIDTH;
    state_t state, state_nxt;
    logic port;
    logic [LEN_W-1:0] remaining;
    logic full_1, full_2, cur_full, term_wr, enq_1, enq_2;
    logic [TW-1:0] enq_data;
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_LOAD;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: state_nxt = (i_run_len != '0) ? S_FILL : S_TERM;
            S_FILL: state_nxt = (i_flush || (o_fifo_in_read && remaining == LEN_W'(1))) ? S_TERM : S_FILL;
            S_TERM: state_nxt = cur_full ? S_TERM : S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end
    // port=0 selects out port 1, port=1 selects out port 2
    always_comb begin
        cur_full = port ? full_2 : full_1;
        o_fifo_in_read = ~i_rst & (state == S_FILL) & ~i_fifo_in_empty & ~cur_full & ~i_flush;
        term_wr = (state == S_TERM) & ~cur_full;
        enq_1 = ~port & (o_fifo_in_read | term_wr);
        enq_2 = port & (o_fifo_in_read | term_wr);
        enq_data = term_wr ? '0 : i_fifo_in;
        o_busy = state != S_LOAD;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            port <= 1'b0;
            remaining <= '0;
            o_run_count <= '0;
        end else begin
            if (state == S_LOAD) remaining <= i_run_len;
            else if (o_fifo_in_read) remaining <= remaining - 1'b1;
            if (term_wr) begin
                port <= ~port;
                o_run_count <= o_run_count + 1'b1;
            end
        end
    end
    stream_fifo #(.W(TW), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(enq_data), .i_enq(enq_1), .i_deq(i_fifo_1_read),
        .o_data(o_fifo_1), .o_empty(o_fifo_1_empty), .o_full(full_1)
    );
    stream_fifo #(.W(TW), .DEPTH(FIFO_DEPTH)) u_fifo_2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(enq_data), .i_enq(enq_2), .i_deq(i_fifo_2_read),
        .o_data(o_fifo_2), .o_empty(o_fifo_2_empty), .o_full(full_2)
    );
endmodule

// File: tb/tb_run_splitter_8.sv
// tb_run_splitter_8: directed self-checking bench for run_splitter_8
module tb_run_splitter_8;
    localparam int DW = 128;
    localparam int TW = 8 * DW;
    localparam int LEN_W = 16;
    typedef logic [TW-1:0] tuple_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    tuple_t fifo_in = '0;
    logic fifo_in_empty = 1'b1;
    logic fifo_in_read;
    logic [LEN_W-1:0] run_len = '0;
    logic flush = 1'b0;
    tuple_t fifo_1, fifo_2;
    logic fifo_1_empty, fifo_2_empty;
    logic fifo_1_read = 1'b0;
    logic fifo_2_read = 1'b0;
    logic [15:0] run_count;
    logic busy;
    tuple_t up_q[$];
    tuple_t cap1[$];
    tuple_t cap2[$];
    int checks = 0;
    int errors = 0;
    int pops = 0;
    logic bubbles = 1'b0;

    always #5 clk = ~clk;

    run_splitter_8 dut (
        .i_clk(clk), .i_rst(rst), .i_fifo_in(fifo_in), .i_fifo_in_empty(fifo_in_empty),
        .o_fifo_in_read(fifo_in_read), .i_run_len(run_len), .i_flush(flush),
        .o_fifo_1(fifo_1), .o_fifo_1_empty(fifo_1_empty), .i_fifo_1_read(fifo_1_read),
        .o_fifo_2(fifo_2), .o_fifo_2_empty(fifo_2_empty), .i_fifo_2_read(fifo_2_read),
        .o_run_count(run_count), .o_busy(busy)
    );

    function automatic tuple_t tup(int v);
        return {8{128'(v)}};
    endfunction

    task automatic drive_up();
        fifo_in_empty = (up_q.size() == 0) || (bubbles && $urandom_range(3) == 0);
        fifo_in = (up_q.size() > 0) ? up_q[0] : '0;
    endtask

    // Samples downstream pops at negedge, advances the upstream model just after posedge.
    task automatic cycle();
        logic pop_now;
        @(negedge clk);
        if (fifo_1_read && !fifo_1_empty) cap1.push_back(fifo_1);
        if (fifo_2_read && !fifo_2_empty) cap2.push_back(fifo_2);
        pop_now = fifo_in_read;
        @(posedge clk);
        #1;
        if (pop_now) begin
            if (up_q.size() > 0) void'(up_q.pop_front());
            pops++;
        end
        drive_up();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_1_read = 1'b0;
        fifo_2_read = 1'b0;
        flush = 1'b0;
        bubbles = 1'b0;
        up_q.delete();
        drive_up();
        cycle();
        rst = 1'b0;
        cap1.delete();
        cap2.delete();
        pops = 0;
    endtask

    task automatic test_reset();
        run_len = 16'd3;
        do_reset();
        #1;
        checks++; if (fifo_1_empty !== 1'b1) begin errors++; $display("FAIL reset_empty1: got %b want 1", fifo_1_empty); end
        checks++; if (fifo_2_empty !== 1'b1) begin errors++; $display("FAIL reset_empty2: got %b want 1", fifo_2_empty); end
        checks++; if (run_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", run_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_in_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", fifo_in_read); end
    endtask

    task automatic test_basic();
        tuple_t got, want;
        run_len = 16'd3;
        do_reset();
        for (int v = 1; v <= 6; v++) up_q.push_back(tup(v));
        drive_up();
        fifo_1_read = 1'b1;
        fifo_2_read = 1'b1;
        repeat (20) cycle();
        checks++;
        if (cap1.size() != 4) begin errors++; $display("FAIL basic_p1_len: got %0d want 4", cap1.size()); end
        else for (int i = 0; i < 4; i++) begin
            want = (i < 3) ? tup(i + 1) : '0;
            got = cap1[i];
            checks++;
            if (got !== want) begin errors++; $display("FAIL basic_p1[%0d]: got %0h want %0h", i, got[31:0], want[31:0]); end
        end
        checks++;
        if (cap2.size() != 4) begin errors++; $display("FAIL basic_p2_len: got %0d want 4", cap2.size()); end
        else for (int i = 0; i < 4; i++) begin
            want = (i < 3) ? tup(i + 4) : '0;
            got = cap2[i];
            checks++;
            if (got !== want) begin errors++; $display("FAIL basic_p2[%0d]: got %0h want %0h", i, got[31:0], want[31:0]); end
        end
        checks++; if (run_count !== 16'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", run_count); end
    endtask

    task automatic test_zero_len();
        int exp_cnt[4] = '{0, 1, 1, 2};
        run_len = 16'd0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (run_count !== 16'(exp_cnt[i])) begin errors++; $display("FAIL zero_count[%0d]: got %0d want %0d", i, run_count, exp_cnt[i]); end
        end
        checks++; if (fifo_1_empty !== 1'b0 || fifo_1 !== '0) begin errors++; $display("FAIL zero_p1: got empty=%b data=%0h want empty=0 data=0", fifo_1_empty, fifo_1[31:0]); end
        checks++; if (fifo_2_empty !== 1'b0 || fifo_2 !== '0) begin errors++; $display("FAIL zero_p2: got empty=%b data=%0h want empty=0 data=0", fifo_2_empty, fifo_2[31:0]); end
    endtask

    task automatic test_backpressure();
        tuple_t got;
        run_len = 16'd20;
        do_reset();
        for (int v = 1; v <= 20; v++) up_q.push_back(tup(v));
        drive_up();
        repeat (25) cycle();
        checks++; if (pops != 16) begin errors++; $display("FAIL bp_pops: got %0d want 16", pops); end
        checks++; if (fifo_in_read !== 1'b0) begin errors++; $display("FAIL bp_read_full: got %b want 0", fifo_in_read); end
        checks++; if (fifo_2_empty !== 1'b1) begin errors++; $display("FAIL bp_idle_port: got %b want 1", fifo_2_empty); end
        fifo_1_read = 1'b1;
        cycle();
        fifo_1_read = 1'b0;
        got = (cap1.size() > 0) ? cap1[0] : '0;
        checks++; if (cap1.size() != 1 || got !== tup(1)) begin errors++; $display("FAIL bp_drain: got n=%0d head=%0h want n=1 head=1", cap1.size(), got[31:0]); end
        checks++; if (fifo_in_read !== 1'b1) begin errors++; $display("FAIL bp_read_resume: got %b want 1", fifo_in_read); end
        cycle();
        checks++; if (pops != 17 || fifo_in_read !== 1'b0) begin errors++; $display("FAIL bp_one_more: got pops=%0d read=%b want pops=17 read=0", pops, fifo_in_read); end
        repeat (5) cycle();
        checks++; if (pops != 17) begin errors++; $display("FAIL bp_hold: got %0d want 17", pops); end
    endtask

    task automatic test_flush();
        tuple_t got, want;
        run_len = 16'd8;
        do_reset();
        for (int v = 1; v <= 5; v++) up_q.push_back(tup(v));
        drive_up();
        fifo_1_read = 1'b1;
        fifo_2_read = 1'b1;
        cycle();
        repeat (3) cycle();
        flush = 1'b1;
        #1;
        checks++; if (fifo_in_read !== 1'b0) begin errors++; $display("FAIL flush_read: got %b want 0", fifo_in_read); end
        cycle();
        flush = 1'b0;
        run_len = 16'd2;
        repeat (15) cycle();
        checks++; if (pops != 5) begin errors++; $display("FAIL flush_pops: got %0d want 5", pops); end
        checks++;
        if (cap1.size() != 4) begin errors++; $display("FAIL flush_p1_len: got %0d want 4", cap1.size()); end
        else for (int i = 0; i < 4; i++) begin
            want = (i < 3) ? tup(i + 1) : '0;
            got = cap1[i];
            checks++;
            if (got !== want) begin errors++; $display("FAIL flush_p1[%0d]: got %0h want %0h", i, got[31:0], want[31:0]); end
        end
        checks++;
        if (cap2.size() != 3) begin errors++; $display("FAIL flush_p2_len: got %0d want 3", cap2.size()); end
        else for (int i = 0; i < 3; i++) begin
            want = (i < 2) ? tup(i + 4) : '0;
            got = cap2[i];
            checks++;
            if (got !== want) begin errors++; $display("FAIL flush_p2[%0d]: got %0h want %0h", i, got[31:0], want[31:0]); end
        end
        checks++; if (run_count !== 16'd2) begin errors++; $display("FAIL flush_count: got %0d want 2", run_count); end
    endtask

    task automatic test_reset_mid();
        run_len = 16'd8;
        do_reset();
        for (int v = 1; v <= 10; v++) up_q.push_back(tup(v));
        drive_up();
        cycle();
        repeat (5) cycle();
        checks++; if (pops != 5 || fifo_1_empty !== 1'b0) begin errors++; $display("FAIL mid_pre: got pops=%0d empty1=%b want pops=5 empty1=0", pops, fifo_1_empty); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        checks++; if (fifo_1_empty !== 1'b1 || fifo_2_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b%b want 11", fifo_1_empty, fifo_2_empty); end
        checks++; if (run_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", run_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (pops != 5) begin errors++; $display("FAIL mid_no_pop: got %0d want 5", pops); end
        cycle();
        cycle();
        checks++; if (fifo_1_empty !== 1'b0 || fifo_1 !== tup(6)) begin errors++; $display("FAIL mid_next_p1: got empty=%b data=%0h want empty=0 data=6", fifo_1_empty, fifo_1[31:0]); end
        checks++; if (fifo_2_empty !== 1'b1) begin errors++; $display("FAIL mid_next_p2: got %b want 1", fifo_2_empty); end
    endtask

    // 1000 tuples in runs of 8: 125 runs, 63 on port 1 and 62 on port 2, 9 entries each.
    task automatic test_random();
        tuple_t got, want;
        int bad, first_bad, idx;
        run_len = 16'd8;
        do_reset();
        for (int v = 1; v <= 1000; v++) up_q.push_back(tup(v));
        bubbles = 1'b1;
        drive_up();
        for (int c = 0; c < 20000 && !(cap1.size() == 567 && cap2.size() == 558); c++) begin
            fifo_1_read = 1'($urandom_range(1));
            fifo_2_read = 1'($urandom_range(1));
            cycle();
        end
        fifo_1_read = 1'b0;
        fifo_2_read = 1'b0;
        bubbles = 1'b0;
        checks++; if (cap1.size() != 567 || cap2.size() != 558) begin errors++; $display("FAIL rand_sizes: got %0d/%0d want 567/558", cap1.size(), cap2.size()); end
        checks++; if (pops != 1000) begin errors++; $display("FAIL rand_pops: got %0d want 1000", pops); end
        checks++; if (run_count !== 16'd125) begin errors++; $display("FAIL rand_count: got %0d want 125", run_count); end
        if (cap1.size() == 567 && cap2.size() == 558) begin
            bad = 0;
            first_bad = -1;
            for (int r = 0; r < 125; r++) begin
                for (int k = 0; k < 9; k++) begin
                    idx = (r / 2) * 9 + k;
                    want = (k < 8) ? tup(r * 8 + k + 1) : '0;
                    got = (r % 2 == 1) ? cap2[idx] : cap1[idx];
                    if (got !== want) begin
                        if (bad == 0) first_bad = r * 9 + k;
                        bad++;
                    end
                end
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rand_order: got %0d wrong entries (first at stream index %0d) want 0", bad, first_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
